// File: rtl/rs485_route_ctrl.sv
// rs485_route_ctrl
// Routes a local UART onto one of NCH RS-485 channels. Ownership only
// changes after the chosen channel has been quiet for IDLE_CYC cycles,
// and each hand-over is framed by GUARD_CYC cycles of safe drive
// (txd=1, de=0, re=0) so neither side can glitch the bus.
module rs485_route_ctrl #(
   parameter int NCH       = 3,
   parameter int IDLE_CYC  = 16,
   parameter int GUARD_CYC = 4,
   localparam int SW = (NCH > 1) ? $clog2(NCH) : 1,
   localparam int CW = $clog2(((IDLE_CYC > GUARD_CYC) ? IDLE_CYC : GUARD_CYC) + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           byp_req,
   input  logic [SW-1:0]  byp_sel,
   output logic           byp_ack,
   output logic           byp_busy,
   output logic           byp_err,
   input  logic           f_tx,
   input  logic           f_re,
   input  logic           f_de,
   output logic           f_rx,
   input  logic [NCH-1:0] mcu_tx,
   input  logic [NCH-1:0] mcu_re,
   input  logic [NCH-1:0] mcu_de,
   output logic [NCH-1:0] mcu_rx,
   output logic [NCH-1:0] bus_txd,
   output logic [NCH-1:0] bus_re,
   output logic [NCH-1:0] bus_de,
   input  logic [NCH-1:0] bus_rxd
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_WAIT_QUIET = 3'd1,
      S_GUARD_IN   = 3'd2,
      S_BYPASS     = 3'd3,
      S_RELEASE    = 3'd4,
      S_GUARD_OUT  = 3'd5
   } state_t;

   localparam logic [CW-1:0] IDLE_LIM  = CW'(IDLE_CYC);
   localparam logic [CW-1:0] GUARD_LIM = CW'(GUARD_CYC);
   localparam logic [CW-1:0] CNT_MAX   = '1;

   state_t        state, state_nx;
   logic [SW-1:0] cur, cur_nx;
   logic [CW-1:0] cnt, cnt_nx, cnt_inc;
   logic          err_lock, err_lock_nx, err_nx;
   logic          sel_ok, quiet_mcu, quiet_loc;

   // The counter saturates so a long quiet stretch can never wrap it back below a limit.
   assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
   assign sel_ok    = (32'(byp_sel) < NCH);
   // Quiet means the current owner is not driving, is idling txd high, and the line idles high.
   assign quiet_mcu = !mcu_de[cur] && mcu_tx[cur] && bus_rxd[cur];
   assign quiet_loc = !f_de && f_tx && bus_rxd[cur];

   // Receive paths are never intercepted.
   assign mcu_rx = bus_rxd;

   // State, channel, counter and status outputs registered; status is taken from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         cur      <= '0;
         cnt      <= '0;
         err_lock <= 1'b0;
         byp_ack  <= 1'b0;
         byp_busy <= 1'b0;
         byp_err  <= 1'b0;
      end else begin
         state    <= state_nx;
         cur      <= cur_nx;
         cnt      <= cnt_nx;
         err_lock <= err_lock_nx;
         byp_ack  <= (state_nx == S_BYPASS);
         byp_busy <= !((state_nx == S_IDLE) || (state_nx == S_BYPASS));
         byp_err  <= err_nx;
      end
   end

   // Next-state, channel latch, quiet/guard counting and error pulse generation.
   always_comb begin
      state_nx    = state;
      cur_nx      = cur;
      cnt_nx      = cnt;
      err_nx      = 1'b0;
      err_lock_nx = err_lock;
      case (state)
         S_IDLE: begin
            if (!byp_req) begin
               err_lock_nx = 1'b0;
            end else if (!err_lock) begin
               if (sel_ok) begin
                  state_nx = S_WAIT_QUIET;
                  cur_nx   = byp_sel;
                  cnt_nx   = '0;
               end else begin
                  // Bad index: flag once, then wait for the request to drop.
                  err_nx      = 1'b1;
                  err_lock_nx = 1'b1;
               end
            end else begin
               err_lock_nx = 1'b1;
            end
         end
         S_WAIT_QUIET: begin
            if (!byp_req) begin
               state_nx = S_IDLE;
               cnt_nx   = '0;
            end else if (quiet_mcu) begin
               if (cnt_inc >= IDLE_LIM) begin
                  state_nx = S_GUARD_IN;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt_inc;
               end
            end else begin
               cnt_nx = '0;
            end
         end
         S_GUARD_IN: begin
            if (cnt_inc >= GUARD_LIM) begin
               state_nx = S_BYPASS;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt_inc;
            end
         end
         S_BYPASS: begin
            if (!byp_req) begin
               state_nx = S_RELEASE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt;
            end
         end
         S_RELEASE: begin
            if (quiet_loc) begin
               if (cnt_inc >= IDLE_LIM) begin
                  state_nx = S_GUARD_OUT;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt_inc;
               end
            end else begin
               cnt_nx = '0;
            end
         end
         S_GUARD_OUT: begin
            if (cnt_inc >= GUARD_LIM) begin
               state_nx = S_IDLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt_inc;
            end
         end
         default: begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   // Pass-through muxing: every channel follows the MCU except the owned one outside IDLE/WAIT_QUIET.
   always_comb begin
      bus_txd = mcu_tx;
      bus_re  = mcu_re;
      bus_de  = mcu_de;
      f_rx    = 1'b1;
      case (state)
         S_GUARD_IN, S_GUARD_OUT: begin
            bus_txd[cur] = 1'b1;
            bus_de[cur]  = 1'b0;
            bus_re[cur]  = 1'b0;
         end
         S_BYPASS: begin
            bus_txd[cur] = f_tx;
            bus_re[cur]  = f_re;
            bus_de[cur]  = f_de;
            f_rx         = bus_rxd[cur];
         end
         S_RELEASE: begin
            bus_txd[cur] = f_tx;
            bus_re[cur]  = f_re;
            bus_de[cur]  = f_de;
         end
         default: begin
            f_rx = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_rs485_route_ctrl.sv
// Self-checking bench for rs485_route_ctrl (NCH=3, IDLE_CYC=16, GUARD_CYC=4).
// Expected outputs are built from the bench's own timeline and pushed to a
// scoreboard queue before each clock; they are popped and compared #1 after it.
module tb_rs485_route_ctrl;

   localparam int PASS = 0;
   localparam int SAFE = 1;
   localparam int LOC  = 2;
   localparam int REL  = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       byp_req;
   logic [1:0] byp_sel;
   logic       byp_ack, byp_busy, byp_err;
   logic       f_tx, f_re, f_de, f_rx;
   logic [2:0] mcu_tx, mcu_re, mcu_de, mcu_rx;
   logic [2:0] bus_txd, bus_re, bus_de, bus_rxd;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic       ack;
      logic       busy;
      logic       err;
      logic       frx;
      logic [2:0] txd;
      logic [2:0] re;
      logic [2:0] de;
      logic [2:0] mrx;
   } exp_t;

   typedef struct packed {
      logic [2:0] tx;
      logic [2:0] re;
      logic [2:0] de;
      logic [2:0] rxd;
      logic       ftx;
      logic       fre;
      logic       fde;
      logic [2:0] etxd;
      logic [2:0] ere;
      logic [2:0] ede;
      logic [2:0] emrx;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[6];

   rs485_route_ctrl #(.NCH(3), .IDLE_CYC(16), .GUARD_CYC(4)) dut (
      .clk(clk), .rst(rst),
      .byp_req(byp_req), .byp_sel(byp_sel),
      .byp_ack(byp_ack), .byp_busy(byp_busy), .byp_err(byp_err),
      .f_tx(f_tx), .f_re(f_re), .f_de(f_de), .f_rx(f_rx),
      .mcu_tx(mcu_tx), .mcu_re(mcu_re), .mcu_de(mcu_de), .mcu_rx(mcu_rx),
      .bus_txd(bus_txd), .bus_re(bus_re), .bus_de(bus_de), .bus_rxd(bus_rxd)
   );

   always #5 clk = ~clk;

   // Expected outputs for the current inputs given the channel ownership mode.
   function automatic exp_t mk(input logic ack, input logic busy, input logic err,
                               input int mode, input int ch);
      exp_t e;
      e.ack  = ack;
      e.busy = busy;
      e.err  = err;
      e.frx  = 1'b1;
      e.txd  = mcu_tx;
      e.re   = mcu_re;
      e.de   = mcu_de;
      e.mrx  = bus_rxd;
      case (mode)
         SAFE: begin
            e.txd[ch] = 1'b1;
            e.de[ch]  = 1'b0;
            e.re[ch]  = 1'b0;
         end
         LOC, REL: begin
            e.txd[ch] = f_tx;
            e.re[ch]  = f_re;
            e.de[ch]  = f_de;
            if (mode == LOC) e.frx = bus_rxd[ch];
         end
         default: e.frx = 1'b1;
      endcase
      return e;
   endfunction

   task automatic step(input exp_t e, input string name);
      exp_t want, got;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      want     = sb_q.pop_front();
      got.ack  = byp_ack;
      got.busy = byp_busy;
      got.err  = byp_err;
      got.frx  = f_rx;
      got.txd  = bus_txd;
      got.re   = bus_re;
      got.de   = bus_de;
      got.mrx  = mcu_rx;
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s @%0t: got ack=%b busy=%b err=%b f_rx=%b txd=%b re=%b de=%b mcu_rx=%b, required ack=%b busy=%b err=%b f_rx=%b txd=%b re=%b de=%b mcu_rx=%b",
                  name, $time, got.ack, got.busy, got.err, got.frx, got.txd, got.re, got.de, got.mrx,
                  want.ack, want.busy, want.err, want.frx, want.txd, want.re, want.de, want.mrx);
      end
   endtask

   // Request channel 1 with it quiet; optional one-cycle mcu_de pulse at step pulse_at.
   task automatic acquire(input int pulse_at, input int nsteps, input string tag);
      int g;
      mcu_tx  = 3'b010;
      mcu_de  = 3'b101;
      mcu_re  = 3'b111;
      bus_rxd = 3'b010;
      f_tx    = 1'b0;
      f_re    = 1'b1;
      f_de    = 1'b1;
      byp_sel = 2'd1;
      byp_req = 1'b1;
      g = (pulse_at < 0) ? 16 : pulse_at + 16;
      for (int k = 0; k < nsteps; k++) begin
         mcu_de[1] = (k == pulse_at);
         if (k < g)          step(mk(1'b0, 1'b1, 1'b0, PASS, 1), {tag, "_quiet"});
         else if (k < g + 4) step(mk(1'b0, 1'b1, 1'b0, SAFE, 1), {tag, "_guard_in"});
         else                step(mk(1'b1, 1'b0, 1'b0, LOC,  1), {tag, "_bypass"});
      end
      mcu_de[1] = 1'b0;
   endtask

   initial begin
      vecs[0] = '{3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000};
      vecs[1] = '{3'b111, 3'b111, 3'b111, 3'b111, 1'b1, 1'b1, 1'b1, 3'b111, 3'b111, 3'b111, 3'b111};
      vecs[2] = '{3'b101, 3'b010, 3'b110, 3'b011, 1'b1, 1'b0, 1'b1, 3'b101, 3'b010, 3'b110, 3'b011};
      vecs[3] = '{3'b010, 3'b101, 3'b001, 3'b100, 1'b0, 1'b1, 1'b0, 3'b010, 3'b101, 3'b001, 3'b100};
      vecs[4] = '{3'b100, 3'b001, 3'b010, 3'b110, 1'b1, 1'b1, 1'b0, 3'b100, 3'b001, 3'b010, 3'b110};
      vecs[5] = '{3'b011, 3'b110, 3'b100, 3'b001, 1'b0, 1'b0, 1'b1, 3'b011, 3'b110, 3'b100, 3'b001};

      rst = 1'b1; byp_req = 1'b0; byp_sel = 2'd0;
      f_tx = 1'b1; f_re = 1'b0; f_de = 1'b0;
      mcu_tx = 3'b101; mcu_re = 3'b011; mcu_de = 3'b110; bus_rxd = 3'b001;
      step(mk(1'b0, 1'b0, 1'b0, PASS, 0), "reset");
      rst = 1'b0;

      // Idle pass-through table
      for (int i = 0; i < 6; i++) begin
         exp_t e;
         mcu_tx = vecs[i].tx; mcu_re = vecs[i].re; mcu_de = vecs[i].de; bus_rxd = vecs[i].rxd;
         f_tx = vecs[i].ftx; f_re = vecs[i].fre; f_de = vecs[i].fde;
         e.ack = 1'b0; e.busy = 1'b0; e.err = 1'b0; e.frx = 1'b1;
         e.txd = vecs[i].etxd; e.re = vecs[i].ere; e.de = vecs[i].ede; e.mrx = vecs[i].emrx;
         step(e, "idle_pass");
      end

      // Clean acquisition: ack from the 21st cycle after the request cycle
      acquire(-1, 24, "acq");
      byp_sel = 2'd2; bus_rxd = 3'b101; f_tx = 1'b0;
      step(mk(1'b1, 1'b0, 1'b0, LOC, 1), "byp_rx_sel_ignored");

      // Release with f_de held 8 cycles, then 16 quiet, 4 guard, pass-through
      byp_req = 1'b0; bus_rxd = 3'b010; f_tx = 1'b1; f_re = 1'b1;
      for (int k = 0; k < 30; k++) begin
         f_de = (k < 8);
         if (k < 23)      step(mk(1'b0, 1'b1, 1'b0, REL,  1), "release");
         else if (k < 27) step(mk(1'b0, 1'b1, 1'b0, SAFE, 1), "guard_out");
         else             step(mk(1'b0, 1'b0, 1'b0, PASS, 1), "after_release");
      end

      // Quiet count broken at 10: ack 11 cycles later; then reset mid-BYPASS
      acquire(11, 34, "pulse");
      rst = 1'b1;
      step(mk(1'b0, 1'b0, 1'b0, PASS, 1), "rst_bypass");
      rst = 1'b0; byp_req = 1'b0;
      step(mk(1'b0, 1'b0, 1'b0, PASS, 1), "rst_bypass_after");

      // Reset during GUARD_IN
      acquire(-1, 18, "rg");
      rst = 1'b1;
      step(mk(1'b0, 1'b0, 1'b0, PASS, 1), "rst_guard");
      rst = 1'b0; byp_req = 1'b0;
      step(mk(1'b0, 1'b0, 1'b0, PASS, 1), "rst_guard_after");

      // Out-of-range select: single error pulse, re-armed only after request drops
      byp_sel = 2'd3; byp_req = 1'b1;
      step(mk(1'b0, 1'b0, 1'b1, PASS, 0), "err_pulse");
      step(mk(1'b0, 1'b0, 1'b0, PASS, 0), "err_once");
      step(mk(1'b0, 1'b0, 1'b0, PASS, 0), "err_hold");
      byp_req = 1'b0;
      step(mk(1'b0, 1'b0, 1'b0, PASS, 0), "err_drop");
      byp_req = 1'b1;
      step(mk(1'b0, 1'b0, 1'b1, PASS, 0), "err_again");
      byp_req = 1'b0;
      step(mk(1'b0, 1'b0, 1'b0, PASS, 0), "err_end");

      // Abort from WAIT_QUIET: no ack, no safe drive
      acquire(-1, 5, "abort");
      byp_req = 1'b0;
      for (int k = 0; k < 6; k++) step(mk(1'b0, 1'b0, 1'b0, PASS, 1), "abort_idle");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
